// File: rtl/cdc_rd_ptr_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : cdc_rd_ptr_sync                                                   |
// | Brief  : Read-domain pointer stage of a CDC FIFO: binary/Gray read         |
// |          pointers, write-pointer synchroniser, fill level, underflow flag. |
// |          Define CDC_RD_SYNC_3STAGE_EN for a 3-flop synchroniser.           |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module cdc_rd_ptr_sync #(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] wrPtr_gray_async,
  input  logic                  fifoRe,
  input  logic                  clrUnderflow,
  output logic [ADDR_WIDTH-1:0] rdPtr_gray,
  output logic [ADDR_WIDTH-1:0] nextrdPtr_gray,
  output logic [ADDR_WIDTH-1:0] wrPtr_gray,
  output logic [ADDR_WIDTH-1:0] rdAddr,
  output logic [ADDR_WIDTH-1:0] rdLevel,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH-1:0] c_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] c_TWO = ADDR_WIDTH'(2);

  function automatic logic [ADDR_WIDTH-1:0] f_bin2gray(input logic [ADDR_WIDTH-1:0] x);
    return x ^ (x >> 1);
  endfunction

  logic [ADDR_WIDTH-1:0] r_rdPtr_bin;
  logic [ADDR_WIDTH-1:0] r_rdPtr_gray;
  logic [ADDR_WIDTH-1:0] r_nextrdPtr_gray;
  logic [ADDR_WIDTH-1:0] r_sync1;
  logic [ADDR_WIDTH-1:0] r_wrPtr_gray;
  logic [ADDR_WIDTH-1:0] r_rdLevel;
  logic                  r_underflow;

  logic [ADDR_WIDTH-1:0] w_rdPtr_bin_next;
  logic [ADDR_WIDTH-1:0] w_wrBin;
  logic                  w_empty;

  assign w_rdPtr_bin_next = fifoRe ? (r_rdPtr_bin + c_ONE) : r_rdPtr_bin;
  assign w_empty          = (r_rdPtr_gray == r_wrPtr_gray);

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_wrBin = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      w_wrBin[i] = ^(r_wrPtr_gray >> i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdPtr_bin      <= '0;
      r_rdPtr_gray     <= '0;
      r_nextrdPtr_gray <= c_ONE;
    end else if (fifoRe) begin
      r_rdPtr_bin      <= r_rdPtr_bin + c_ONE;
      r_rdPtr_gray     <= r_nextrdPtr_gray;
      r_nextrdPtr_gray <= f_bin2gray(r_rdPtr_bin + c_TWO);
    end
  end

`ifdef CDC_RD_SYNC_3STAGE_EN
  logic [ADDR_WIDTH-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_wrPtr_gray <= '0;
    end else begin
      r_sync1      <= wrPtr_gray_async;
      r_sync2      <= r_sync1;
      r_wrPtr_gray <= r_sync2;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1      <= '0;
      r_wrPtr_gray <= '0;
    end else begin
      r_sync1      <= wrPtr_gray_async;
      r_wrPtr_gray <= r_sync1;
    end
  end
`endif

  // Level is taken against the post-edge read pointer so it matches the pointers next cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdLevel   <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_rdLevel <= w_wrBin - w_rdPtr_bin_next;
      if (fifoRe && w_empty) begin
        r_underflow <= 1'b1;
      end else if (clrUnderflow) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign rdPtr_gray     = r_rdPtr_gray;
  assign nextrdPtr_gray = r_nextrdPtr_gray;
  assign wrPtr_gray     = r_wrPtr_gray;
  assign rdAddr         = r_rdPtr_bin;
  assign rdLevel        = r_rdLevel;
  assign underflow      = r_underflow;

endmodule
`default_nettype wire
